// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if: request, ALU and response signals of the two-port ALU arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             flush;

  logic             req0_valid;
  logic             req0_ready;
  logic [5:0]       req0_alucode;
  logic [31:0]      req0_op1;
  logic [31:0]      req0_op2;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [5:0]       req1_alucode;
  logic [31:0]      req1_op1;
  logic [31:0]      req1_op2;
  logic [TAG_W-1:0] req1_tag;

  logic [5:0]       alu_alucode;
  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  logic [31:0]      alu_result;
  logic             alu_br_taken;
  logic [1:0]       alu_mem_access_width;
  logic             alu_is_load_unsigned;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [31:0]      rsp0_result;
  logic             rsp0_br_taken;
  logic [1:0]       rsp0_mem_width;
  logic             rsp0_load_unsigned;
  logic [TAG_W-1:0] rsp0_tag;

  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [31:0]      rsp1_result;
  logic             rsp1_br_taken;
  logic [1:0]       rsp1_mem_width;
  logic             rsp1_load_unsigned;
  logic [TAG_W-1:0] rsp1_tag;

  // slave: the arbiter itself; master: requesters, consumers and the ALU
  modport slave (
    input  flush,
    input  req0_valid, req0_alucode, req0_op1, req0_op2, req0_tag,
    output req0_ready,
    input  req1_valid, req1_alucode, req1_op1, req1_op2, req1_tag,
    output req1_ready,
    output alu_alucode, alu_op1, alu_op2,
    input  alu_result, alu_br_taken, alu_mem_access_width, alu_is_load_unsigned,
    output rsp0_valid, rsp0_result, rsp0_br_taken, rsp0_mem_width, rsp0_load_unsigned, rsp0_tag,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_br_taken, rsp1_mem_width, rsp1_load_unsigned, rsp1_tag,
    input  rsp1_ready
  );

  modport master (
    output flush,
    output req0_valid, req0_alucode, req0_op1, req0_op2, req0_tag,
    input  req0_ready,
    output req1_valid, req1_alucode, req1_op1, req1_op2, req1_tag,
    input  req1_ready,
    input  alu_alucode, alu_op1, alu_op2,
    output alu_result, alu_br_taken, alu_mem_access_width, alu_is_load_unsigned,
    input  rsp0_valid, rsp0_result, rsp0_br_taken, rsp0_mem_width, rsp0_load_unsigned, rsp0_tag,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_br_taken, rsp1_mem_width, rsp1_load_unsigned, rsp1_tag,
    output rsp1_ready
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter: round-robin sharing of one combinational ALU by two requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  // Encodings shared with define.vh
  localparam logic [5:0] ALU_NOP  = 6'd0;
  localparam logic [1:0] MEM_NONE = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  logic [1:0]            w_req_valid;
  logic [1:0][5:0]       w_req_code;
  logic [1:0][31:0]      w_req_op1;
  logic [1:0][31:0]      w_req_op2;
  logic [1:0][TAG_W-1:0] w_req_tag;
  logic [1:0]            w_rsp_ready;

  logic [1:0]            w_full;
  logic [1:0]            w_elig;
  logic [1:0]            w_grant;

  logic [1:0][31:0]      w_rsp_result;
  logic [1:0]            w_rsp_br;
  logic [1:0][1:0]       w_rsp_width;
  logic [1:0]            w_rsp_lu;
  logic [1:0][TAG_W-1:0] w_rsp_tag;

  logic                  prio_q;
  logic                  prio_d;

  assign w_req_valid = {bus.req1_valid, bus.req0_valid};
  assign w_req_code  = {bus.req1_alucode, bus.req0_alucode};
  assign w_req_op1   = {bus.req1_op1, bus.req0_op1};
  assign w_req_op2   = {bus.req1_op2, bus.req0_op2};
  assign w_req_tag   = {bus.req1_tag, bus.req0_tag};
  assign w_rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    slot_e            slot_q;
    slot_e            slot_d;
    logic [31:0]      result_q;
    logic             br_q;
    logic [1:0]       width_q;
    logic             lu_q;
    logic [TAG_W-1:0] tag_q;

    assign w_full[gi] = (slot_q == FULL);

    // rst_n gating keeps req_ready low while reset is held
    assign w_elig[gi] = rst_n & ~bus.flush & w_req_valid[gi]
                      & (~w_full[gi] | w_rsp_ready[gi]);

    always_comb begin
      slot_d = slot_q;
      case (slot_q)
        EMPTY:   if (w_grant[gi]) slot_d = FULL;
        FULL:    if (!w_grant[gi] && w_rsp_ready[gi]) slot_d = EMPTY;
        default: slot_d = EMPTY;
      endcase
      if (bus.flush) slot_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q <= EMPTY;
      end else begin
        slot_q <= slot_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        result_q <= '0;
        br_q     <= 1'b0;
        width_q  <= MEM_NONE;
        lu_q     <= 1'b0;
        tag_q    <= '0;
      end else if (w_grant[gi]) begin
        result_q <= bus.alu_result;
        br_q     <= bus.alu_br_taken;
        width_q  <= bus.alu_mem_access_width;
        lu_q     <= bus.alu_is_load_unsigned;
        tag_q    <= w_req_tag[gi];
      end
    end

    assign w_rsp_result[gi] = result_q;
    assign w_rsp_br[gi]     = br_q;
    assign w_rsp_width[gi]  = width_q;
    assign w_rsp_lu[gi]     = lu_q;
    assign w_rsp_tag[gi]    = tag_q;
  end

  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (w_grant[0]) begin
      prio_d = 1'b1;
    end else if (w_grant[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    bus.alu_alucode = ALU_NOP;
    bus.alu_op1     = '0;
    bus.alu_op2     = '0;
    if (w_grant[0]) begin
      bus.alu_alucode = w_req_code[0];
      bus.alu_op1     = w_req_op1[0];
      bus.alu_op2     = w_req_op2[0];
    end else if (w_grant[1]) begin
      bus.alu_alucode = w_req_code[1];
      bus.alu_op1     = w_req_op1[1];
      bus.alu_op2     = w_req_op2[1];
    end
  end

  assign bus.req0_ready         = w_grant[0];
  assign bus.req1_ready         = w_grant[1];

  assign bus.rsp0_valid         = w_full[0];
  assign bus.rsp0_result        = w_rsp_result[0];
  assign bus.rsp0_br_taken      = w_rsp_br[0];
  assign bus.rsp0_mem_width     = w_rsp_width[0];
  assign bus.rsp0_load_unsigned = w_rsp_lu[0];
  assign bus.rsp0_tag           = w_rsp_tag[0];

  assign bus.rsp1_valid         = w_full[1];
  assign bus.rsp1_result        = w_rsp_result[1];
  assign bus.rsp1_br_taken      = w_rsp_br[1];
  assign bus.rsp1_mem_width     = w_rsp_width[1];
  assign bus.rsp1_load_unsigned = w_rsp_lu[1];
  assign bus.rsp1_tag           = w_rsp_tag[1];

endmodule

`default_nettype wire
